decoder: RTL and testbench

DECODER -- requirements
Module: decoder

---
 rtl/decoder_if.sv | 29 ++
 rtl/decoder.sv | 72 +++++++
 tb/tb_decoder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/decoder_if.sv
// Request/result bundle for the Hamming decoder. The err_flag signal is present
// only when DECODER_ERR_FLAG_EN is defined.
interface decoder_if;
  logic        in_valid;
  logic [31:0] data_in;
  logic        out_valid;
  logic [31:0] data_out;
  logic [4:0]  do_XOR;
  logic [4:0]  M;
`ifdef DECODER_ERR_FLAG_EN
  logic        err_flag;
`endif

  modport master (
    output in_valid, data_in,
`ifdef DECODER_ERR_FLAG_EN
    input  err_flag,
`endif
    input  out_valid, data_out, do_XOR, M
  );

  modport slave (
    input  in_valid, data_in,
`ifdef DECODER_ERR_FLAG_EN
    output err_flag,
`endif
    output out_valid, data_out, do_XOR, M
  );
endinterface

// File: rtl/decoder.sv
// Single-error-correcting Hamming decoder over codeword bits [30:0], one-cycle latency.
// Optional registered err_flag output is enabled with DECODER_ERR_FLAG_EN.
module decoder (
  input  logic      clk,
  input  logic      rst_n,
  decoder_if.slave  bus
);

  logic [4:0]  syn_d;
  logic [4:0]  len_d;
  logic [31:0] data_d;

  logic        valid_q;
  logic [31:0] data_q;
  logic [4:0]  syn_q;
  logic [4:0]  len_q;

  always_comb begin
    syn_d = 5'd0;
    len_d = 5'd0;
    for (int p = 1; p < 32; p++) begin
      if (bus.data_in[p-1]) begin
        syn_d = syn_d ^ 5'(p);
        len_d = 5'(p);
      end
    end
  end

  // A syndrome beyond the codeword length cannot name a real bit, so leave the word alone.
  always_comb begin
    data_d = bus.data_in;
    if (syn_d != 5'd0 && syn_d <= len_d) begin
      data_d[syn_d - 5'd1] = ~bus.data_in[syn_d - 5'd1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= 32'd0;
      syn_q   <= 5'd0;
      len_q   <= 5'd0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        data_q <= data_d;
        syn_q  <= syn_d;
        len_q  <= len_d;
      end
    end
  end

`ifdef DECODER_ERR_FLAG_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (bus.in_valid) begin
      err_q <= (syn_d != 5'd0);
    end
  end

  assign bus.err_flag = err_q;
`endif

  assign bus.out_valid = valid_q;
  assign bus.data_out  = data_q;
  assign bus.do_XOR    = syn_q;
  assign bus.M         = len_q;

endmodule

// File: tb/tb_decoder.sv
// Randomized self-checking bench for decoder against a parity-count reference model.
module tb_decoder;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  decoder_if bus ();

  decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic        exp_valid;
  logic [31:0] exp_data;
  logic [4:0]  exp_syn;
  logic [4:0]  exp_len;
  logic        exp_err;

  initial begin
    clk = 1'b0;
    #5;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Syndrome bit k is the parity of how many set positions have bit k in their index.
  function automatic void model(input logic [31:0] d, output logic [4:0] s,
                                output logic [4:0] m, output logic [31:0] o);
    int cnt;
    int x;
    for (int k = 0; k < 5; k++) begin
      cnt = 0;
      for (int p = 1; p < 32; p++)
        if (d[p-1] && ((p >> k) & 1) == 1) cnt++;
      s[k] = (cnt % 2) == 1;
    end
    x = int'(d[30:0]);
    m = 5'($clog2(x + 1));
    o = d;
    if (s != 5'd0 && s <= m) o = d ^ (32'd1 << (s - 5'd1));
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(exp_valid));
    check({tag, ".data"},  bus.data_out,       exp_data);
    check({tag, ".syn"},   32'(bus.do_XOR),    32'(exp_syn));
    check({tag, ".len"},   32'(bus.M),         32'(exp_len));
`ifdef DECODER_ERR_FLAG_EN
    check({tag, ".err"},   32'(bus.err_flag),  32'(exp_err));
`endif
  endtask

  task automatic step(input string tag, input logic v, input logic [31:0] d);
    logic [4:0]  s;
    logic [4:0]  m;
    logic [31:0] o;
    bus.in_valid = v;
    bus.data_in  = d;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      exp_valid = 1'b0; exp_data = '0; exp_syn = '0; exp_len = '0; exp_err = 1'b0;
    end else begin
      exp_valid = v;
      if (v) begin
        model(d, s, m, o);
        exp_data = o; exp_syn = s; exp_len = m; exp_err = (s != 5'd0);
      end
    end
    check_outputs(tag);
  endtask

  task automatic directed(input string tag, input logic [31:0] d, input logic [31:0] eo,
                          input logic [4:0] es, input logic [4:0] em);
    step(tag, 1'b1, d);
    check({tag, ".fixed_syn"},  32'(bus.do_XOR), 32'(es));
    check({tag, ".fixed_len"},  32'(bus.M),      32'(em));
    check({tag, ".fixed_data"}, bus.data_out,    eo);
  endtask

  initial begin
    logic [31:0] w1;
    logic [31:0] w2;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.data_in = $urandom;
    exp_valid = 1'b0; exp_data = '0; exp_syn = '0; exp_len = '0; exp_err = 1'b0;

    #1;
    check_outputs("reset_pre_clk");
    step("reset_clocked", 1'b1, $urandom);
    #2;
    rst_n = 1'b1;
    step("post_release_idle", 1'b0, $urandom);

    directed("single_err", 32'b1101110101, 32'b1101100101, 5'd5, 5'd10);
    directed("clean",      32'h0000_0007,  32'h0000_0007,  5'd0, 5'd3);
    directed("out_range",  32'h0000_0003,  32'h0000_0003,  5'd3, 5'd2);
    directed("bit31",      32'h8000_0001,  32'h8000_0000,  5'd1, 5'd1);
    directed("zero",       32'h8000_0000,  32'h8000_0000,  5'd0, 5'd0);

    w1 = $urandom;
    w2 = $urandom;
    step("hold_w1", 1'b1, w1);
    step("hold_w2", 1'b1, w2);
    for (int i = 0; i < 3; i++) step("hold_idle", 1'b0, $urandom);

    // Mid-stream reset: outputs clear immediately and the sample taken in reset is dropped.
    step("pre_reset", 1'b1, $urandom);
    rst_n = 1'b0;
    #1;
    exp_valid = 1'b0; exp_data = '0; exp_syn = '0; exp_len = '0; exp_err = 1'b0;
    check_outputs("async_reset");
    step("in_reset", 1'b1, $urandom);
    rst_n = 1'b1;
    step("after_reset_idle", 1'b0, $urandom);
    step("after_reset_first", 1'b1, $urandom);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] d;
      d = $urandom;
      if ($urandom_range(0, 3) == 0) d = d & (32'hFFFF_FFFF >> $urandom_range(1, 31));
      step("random", $urandom_range(0, 3) != 0, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
